fx3_slfifo_responder: RTL and testbench
=======================================

FX3_SLFIFO_RESPONDER -- requirements
Module: fx3_slfifo_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving loopback buffer depth in 32-bit words (power of two, 4..256).
REQ-002 The block SHALL have parameter AFULL_TH, default 2, giving the almost-full margin in words.
REQ-003 The block SHALL have parameter AEMPTY_TH, default 2, giving the almost-empty margin in words.
REQ-004 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port fx3_slcs_n, input, 1 bit: chip select, active low.
REQ-007 Port fx3_slwr_n, input, 1 bit: write strobe, active low.
REQ-008 Port fx3_slrd_n, input, 1 bit: read strobe, active low.
REQ-009 Port fx3_sloe_n, input, 1 bit: output enable, active low.
REQ-010 Port fx3_pktend_n, input, 1 bit: packet end, active low.
REQ-011 Port fx3_a, input, 2 bits: thread address; 2'b00 selects the write thread, 2'b11 selects the read thread.
REQ-012 Port fx3_db, inout, 32 bits: data bus.
REQ-013 Port fx3_flaga, output, 1 bit: write-full flag, low when the buffer is full.
REQ-014 Port fx3_flagb, output, 1 bit: write-almost-full flag, low when fill >= DEPTH-AFULL_TH.
REQ-015 Port fx3_flagc, output, 1 bit: read-empty flag, low when fill == 0.
REQ-016 Port fx3_flagd, output, 1 bit: read-almost-empty flag, low when fill <= AEMPTY_TH.
REQ-017 Port fill_level, output, clog2(DEPTH)+1 bits: current word count.
REQ-018 Port pkt_cnt, output, 16 bits: count of accepted pktend events.
REQ-019 Port ovf_cnt, output, 8 bits: count of dropped writes.
REQ-020 Port udf_cnt, output, 8 bits: count of ignored reads.

Function
REQ-021 The block SHALL be the slave end of the synchronous Slave FIFO bus and loop data written on thread 00 back out on thread 11 in FIFO order.
REQ-022 Write: a word SHALL be accepted when slcs_n=0, slwr_n=0, a=00 and the buffer is not full at that edge.
REQ-023 A write while the buffer is full SHALL be dropped with no change to contents or pointers.
REQ-024 Read: a word SHALL be popped when slcs_n=0, slrd_n=0, a=11 and the buffer is not empty at that edge.
REQ-025 Read latency SHALL be 2 cycles: the word popped at edge N appears in the output register after edge N+2.
REQ-026 The output register SHALL hold its value when no pop completes, including a read while empty.
REQ-027 fx3_db SHALL be driven from the output register only while slcs_n=0, sloe_n=0 and a=11, and SHALL be high-Z otherwise (combinational enable).
REQ-028 A simultaneous accepted write and pop in one cycle SHALL leave fill unchanged.
REQ-029 A simultaneous write and pop with the buffer full SHALL pop and drop the write.
REQ-030 A simultaneous write and pop with the buffer empty SHALL accept the write and ignore the pop.
REQ-031 Pointers SHALL wrap modulo DEPTH.
REQ-032 Flags SHALL be registered and reflect fill one cycle after the causing edge.
REQ-033 pktend: slcs_n=0, pktend_n=0, a=00 in a cycle SHALL increment pkt_cnt by 1, wrapping at 16 bits, whether or not slwr_n is low; the data path is unaffected.

Reset
REQ-034 On rst high, the block SHALL immediately clear the pointers and fill_level.
REQ-035 On rst high, the output register SHALL go to 32'h0.
REQ-036 On rst high, pkt_cnt, ovf_cnt and udf_cnt SHALL go to 0.
REQ-037 On rst high, flags SHALL go to flaga=1, flagb=1, flagc=0, flagd=0.
REQ-038 Reset asserted mid-transfer SHALL discard buffered data and any in-flight read pipeline.
REQ-039 fx3_db SHALL be high-Z while rst is high.

Configuration
REQ-040 With macro SLFIFO_ERRCNT_EN defined, ovf_cnt SHALL count dropped writes and udf_cnt SHALL count ignored reads, each saturating at 8'hFF.
REQ-041 With SLFIFO_ERRCNT_EN undefined, ovf_cnt and udf_cnt SHALL be constant 0 with no counter logic, and the ports SHALL remain present.

Verification
REQ-042 Reset, then write 4 words 0x11111111..0x44444444 on a=00 → fill_level=4 one cycle later; flagc=1, flagd=1.
REQ-043 Read 4 words on a=11 with sloe_n=0 → fx3_db shows 0x11111111..0x44444444 starting 2 cycles after the first slrd_n low; flagc=0 after the last pop.
REQ-044 Write 18 words with DEPTH=16 → flagb low at fill 14, flaga low at fill 16; 2 writes dropped; ovf_cnt=2 with SLFIFO_ERRCNT_EN, 0 without.
REQ-045 Full buffer, simultaneous write and read for 5 cycles → fill_level stays 16; words popped are the oldest 5.
REQ-046 Pulse pktend_n low 3 times on a=00 with slwr_n high → pkt_cnt=3 and fill unchanged; then assert rst mid-read → fill 0, pkt_cnt 0, fx3_db high-Z.

Source files
------------

// File: rtl/fx3_slfifo_responder.sv
// fx3_slfifo_responder
//   Slave end of the FX3 synchronous Slave FIFO bus. Words written on thread
//   2'b00 are buffered and returned in FIFO order on thread 2'b11.
//
// Parameters
//   DEPTH     : loopback buffer depth in 32-bit words (power of two, 4..256)
//   AFULL_TH  : almost-full margin in words (flagb low when fill >= DEPTH-AFULL_TH)
//   AEMPTY_TH : almost-empty margin in words (flagd low when fill <= AEMPTY_TH)
//
// Ports
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   fx3_slcs_n/slwr_n/slrd_n/sloe_n/pktend_n : active-low bus strobes
//   fx3_a                : thread address (00 = write thread, 11 = read thread)
//   fx3_db               : bidirectional 32-bit data bus
//   fx3_flaga..flagd     : registered full / almost-full / empty / almost-empty
//                          flags, all active low
//   fill_level           : current word count
//   pkt_cnt              : accepted pktend events (wraps at 16 bits)
//   ovf_cnt, udf_cnt     : dropped writes / ignored reads (saturating)
//
// Build option
//   SLFIFO_ERRCNT_EN : when defined, ovf_cnt/udf_cnt count; otherwise they are
//                      tied to zero and no counter logic is built.

module fx3_slfifo_responder #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_TH  = 2,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fx3_slcs_n,
    input  logic                     fx3_slwr_n,
    input  logic                     fx3_slrd_n,
    input  logic                     fx3_sloe_n,
    input  logic                     fx3_pktend_n,
    input  logic [1:0]               fx3_a,
    inout  wire  [31:0]              fx3_db,
    output logic                     fx3_flaga,
    output logic                     fx3_flagb,
    output logic                     fx3_flagc,
    output logic                     fx3_flagd,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [15:0]              pkt_cnt,
    output logic [7:0]               ovf_cnt,
    output logic [7:0]               udf_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    localparam logic [FW-1:0] FullLvl   = FW'(DEPTH);
    localparam logic [FW-1:0] AfullLvl  = FW'(DEPTH - AFULL_TH);
    localparam logic [FW-1:0] AemptyLvl = FW'(AEMPTY_TH);

    // Storage and pointers
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;

    // Two-stage read pipeline: stage A holds the popped address, stage B the
    // fetched word, then the output register.
    logic          rd_vld_a_q, rd_vld_a_d;
    logic [AW-1:0] rd_addr_a_q, rd_addr_a_d;
    logic          rd_vld_b_q, rd_vld_b_d;
    logic [31:0]   rd_data_b_q, rd_data_b_d;
    logic [31:0]   out_q, out_d;

    logic          flaga_q, flaga_d;
    logic          flagb_q, flagb_d;
    logic          flagc_q, flagc_d;
    logic          flagd_q, flagd_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;

    logic wr_req, rd_req, pkt_req;
    logic full, empty;
    logic do_wr, do_rd;
    logic db_oe;

    assign wr_req  = !fx3_slcs_n && !fx3_slwr_n   && (fx3_a == 2'b00);
    assign rd_req  = !fx3_slcs_n && !fx3_slrd_n   && (fx3_a == 2'b11);
    assign pkt_req = !fx3_slcs_n && !fx3_pktend_n && (fx3_a == 2'b00);

    assign full  = (fill_q == FullLvl);
    assign empty = (fill_q == '0);

    // Full with a concurrent pop still drops the write; empty with a
    // concurrent write still ignores the pop.
    assign do_wr = wr_req && !full;
    assign do_rd = rd_req && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        rd_vld_a_d  = do_rd;
        rd_addr_a_d = rd_ptr_q;
        rd_vld_b_d  = rd_vld_a_q;
        rd_data_b_d = rd_data_b_q;
        out_d       = out_q;
        pkt_cnt_d   = pkt_cnt_q;

        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);

        case ({do_wr, do_rd})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase

        // A write landing on the just-popped slot (buffer was full) happens at
        // the same edge as this fetch at the earliest, so the old word is read.
        if (rd_vld_a_q) rd_data_b_d = mem_q[rd_addr_a_q];
        if (rd_vld_b_q) out_d = rd_data_b_q;

        if (pkt_req) pkt_cnt_d = pkt_cnt_q + 16'd1;

        // Flags track the new fill so they change on the same edge as fill_level.
        flaga_d = (fill_d != FullLvl);
        flagb_d = (fill_d < AfullLvl);
        flagc_d = (fill_d != '0);
        flagd_d = (fill_d > AemptyLvl);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            rd_vld_a_q  <= 1'b0;
            rd_addr_a_q <= '0;
            rd_vld_b_q  <= 1'b0;
            rd_data_b_q <= '0;
            out_q       <= '0;
            flaga_q     <= 1'b1;
            flagb_q     <= 1'b1;
            flagc_q     <= 1'b0;
            flagd_q     <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            rd_vld_a_q  <= rd_vld_a_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_vld_b_q  <= rd_vld_b_d;
            rd_data_b_q <= rd_data_b_d;
            out_q       <= out_d;
            flaga_q     <= flaga_d;
            flagb_q     <= flagb_d;
            flagc_q     <= flagc_d;
            flagd_q     <= flagd_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // Buffer contents need no reset; pointers and fill define validity.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= fx3_db;
    end

`ifdef SLFIFO_ERRCNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;
    logic [7:0] udf_cnt_q, udf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
        if (wr_req && full && (ovf_cnt_q != 8'hFF))  ovf_cnt_d = ovf_cnt_q + 8'd1;
        if (rd_req && empty && (udf_cnt_q != 8'hFF)) udf_cnt_d = udf_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`else
    assign ovf_cnt = 8'h00;
    assign udf_cnt = 8'h00;
`endif

    // Bus enable is combinational so the FX3 sees data as soon as it selects
    // the read thread with output enable; released while in reset.
    assign db_oe  = !rst && !fx3_slcs_n && !fx3_sloe_n && (fx3_a == 2'b11);
    assign fx3_db = db_oe ? out_q : 32'hzzzz_zzzz;

    assign fx3_flaga  = flaga_q;
    assign fx3_flagb  = flagb_q;
    assign fx3_flagc  = flagc_q;
    assign fx3_flagd  = flagd_q;
    assign fill_level = fill_q;
    assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_fx3_slfifo_responder.sv
// Self-checking bench for fx3_slfifo_responder (DEPTH=16, AFULL_TH=2, AEMPTY_TH=2).
// Expected values come from a queue-based model of the loopback buffer and
// from hand-computed vector tables.

module tb_fx3_slfifo_responder;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cs_n, wr_n, rd_n, oe_n, pk_n;
    logic [1:0]  a;
    logic        drv_en;
    logic [31:0] drv_val, wdata;
    wire  [31:0] fx3_db;

    logic        flaga, flagb, flagc, flagd;
    logic [4:0]  fill_level;
    logic [15:0] pkt_cnt;
    logic [7:0]  ovf_cnt, udf_cnt;

    // Bench drives the bus whenever the DUT must not; driving 0 there makes a
    // spurious DUT drive visible on the resolved net.
    assign fx3_db = drv_en ? drv_val : 32'hzzzz_zzzz;

    fx3_slfifo_responder #(
        .DEPTH    (16),
        .AFULL_TH (2),
        .AEMPTY_TH(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fx3_slcs_n  (cs_n),
        .fx3_slwr_n  (wr_n),
        .fx3_slrd_n  (rd_n),
        .fx3_sloe_n  (oe_n),
        .fx3_pktend_n(pk_n),
        .fx3_a       (a),
        .fx3_db      (fx3_db),
        .fx3_flaga   (flaga),
        .fx3_flagb   (flagb),
        .fx3_flagc   (flagc),
        .fx3_flagd   (flagd),
        .fill_level  (fill_level),
        .pkt_cnt     (pkt_cnt),
        .ovf_cnt     (ovf_cnt),
        .udf_cnt     (udf_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] w;
        int          e;
    } pop_t;

    logic [31:0] mq[$];
    pop_t        popq[$];
    int          edge_no;
    logic [31:0] out_m;
    int          pkt_m, ovf_m, udf_m;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic model_reset();
        mq.delete();
        popq.delete();
        out_m = 32'h0;
        pkt_m = 0;
        ovf_m = 0;
        udf_m = 0;
        edge_no = 0;
    endtask

    // One rising edge: pop from the front, push at the back, a popped word
    // reaches the output register two edges after its pop.
    task automatic model_edge();
        bit wr, rd, dp, dw;
        logic [31:0] w;
        if (rst) begin
            model_reset();
            return;
        end
        wr = !cs_n && !wr_n && (a == 2'b00);
        rd = !cs_n && !rd_n && (a == 2'b11);
        dp = rd && (mq.size() > 0);
        dw = wr && (mq.size() < DEPTH);
        while (popq.size() > 0 && popq[0].e + 2 <= edge_no) begin
            out_m = popq[0].w;
            void'(popq.pop_front());
        end
        if (dp) begin
            w = mq.pop_front();
            popq.push_back('{w, edge_no});
        end
        if (dw) mq.push_back(wdata);
        if (wr && !dw && ovf_m < 255) ovf_m++;
        if (rd && !dp && udf_m < 255) udf_m++;
        if (!cs_n && !pk_n && (a == 2'b00)) pkt_m = (pkt_m + 1) % 65536;
        edge_no++;
    endtask

    function automatic logic dut_should_drive();
        return !rst && !cs_n && !oe_n && (a == 2'b11);
    endfunction

    task automatic update_bus();
        drv_en  = !dut_should_drive();
        drv_val = (a == 2'b00) ? wdata : 32'h0;
    endtask

    task automatic drive(input logic cs, input logic wr, input logic rd, input logic oe,
                         input logic pk, input logic [1:0] aa, input logic [31:0] d);
        cs_n  = cs;
        wr_n  = wr;
        rd_n  = rd;
        oe_n  = oe;
        pk_n  = pk;
        a     = aa;
        wdata = d;
        update_bus();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_flags(input int f);
        return {f != DEPTH, f < DEPTH - 2, f != 0, f > 2};
    endfunction

    task automatic check_all(input string tag);
        int f;
        f = mq.size();
        chk({tag, " fill"}, 32'(fill_level), 32'(f));
        chk({tag, " flags"}, 32'({flaga, flagb, flagc, flagd}), 32'(exp_flags(f)));
        chk({tag, " pkt"}, 32'(pkt_cnt), 32'(pkt_m));
`ifdef SLFIFO_ERRCNT_EN
        chk({tag, " ovf"}, 32'(ovf_cnt), 32'(ovf_m));
        chk({tag, " udf"}, 32'(udf_cnt), 32'(udf_m));
`else
        chk({tag, " ovf"}, 32'(ovf_cnt), 32'h0);
        chk({tag, " udf"}, 32'(udf_cnt), 32'h0);
`endif
        chk({tag, " db"}, fx3_db, dut_should_drive() ? out_m : drv_val);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        update_bus();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst fill", 32'(fill_level), 32'h0);
        chk("rst flags", 32'({flaga, flagb, flagc, flagd}), 32'b1100);
        chk("rst pkt", 32'(pkt_cnt), 32'h0);
        chk("rst ovf", 32'(ovf_cnt), 32'h0);
        chk("rst udf", 32'(udf_cnt), 32'h0);
        chk("rst db", fx3_db, 32'h0);
        rst = 1'b0;
        update_bus();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        cs_n, wr_n, rd_n, oe_n;
        logic [1:0]  a;
        logic [31:0] data;
        logic [4:0]  fill;
        logic [3:0]  flags;
        logic [31:0] db;
    } vec_t;

    function automatic vec_t mk(input logic cs, input logic wr, input logic rd, input logic oe,
                                input logic [1:0] aa, input logic [31:0] d,
                                input logic [4:0] f, input logic [3:0] fl,
                                input logic [31:0] db);
        vec_t v;
        v.cs_n = cs; v.wr_n = wr; v.rd_n = rd; v.oe_n = oe;
        v.a = aa; v.data = d; v.fill = f; v.flags = fl; v.db = db;
        return v;
    endfunction

    vec_t vecs[12];
    localparam logic [31:0] Base = 32'hA000_0000;

    initial begin
        vecs[0]  = mk(0, 0, 1, 1, 2'b00, 32'h11111111, 1, 4'b1110, 32'h11111111);
        vecs[1]  = mk(0, 0, 1, 1, 2'b00, 32'h22222222, 2, 4'b1110, 32'h22222222);
        vecs[2]  = mk(0, 0, 1, 1, 2'b00, 32'h33333333, 3, 4'b1111, 32'h33333333);
        vecs[3]  = mk(0, 0, 1, 1, 2'b00, 32'h44444444, 4, 4'b1111, 32'h44444444);
        vecs[4]  = mk(0, 1, 0, 0, 2'b11, 32'h0, 3, 4'b1111, 32'h00000000);
        vecs[5]  = mk(0, 1, 0, 0, 2'b11, 32'h0, 2, 4'b1110, 32'h00000000);
        vecs[6]  = mk(0, 1, 0, 0, 2'b11, 32'h0, 1, 4'b1110, 32'h11111111);
        vecs[7]  = mk(0, 1, 0, 0, 2'b11, 32'h0, 0, 4'b1100, 32'h22222222);
        vecs[8]  = mk(0, 1, 1, 0, 2'b11, 32'h0, 0, 4'b1100, 32'h33333333);
        vecs[9]  = mk(0, 1, 1, 0, 2'b11, 32'h0, 0, 4'b1100, 32'h44444444);
        vecs[10] = mk(0, 1, 0, 0, 2'b11, 32'h0, 0, 4'b1100, 32'h44444444);
        // Deselected: bus released, the bench's 0 must be seen.
        vecs[11] = mk(1, 1, 0, 0, 2'b11, 32'h0, 0, 4'b1100, 32'h00000000);

        rst = 1'b1;
        drive(1, 1, 1, 1, 1, 2'b00, 32'h0);
        model_reset();
        #12;
        do_reset();

        // Output register reset value on the bus.
        drive(0, 1, 1, 0, 1, 2'b11, 32'h0);
        step("idle");
        chk("out reset value", fx3_db, 32'h0);

        // Basic write/read loopback table.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].cs_n, vecs[i].wr_n, vecs[i].rd_n, vecs[i].oe_n, 1'b1,
                  vecs[i].a, vecs[i].data);
            step("vec");
            chk($sformatf("vec%0d fill", i), 32'(fill_level), 32'(vecs[i].fill));
            chk($sformatf("vec%0d flags", i), 32'({flaga, flagb, flagc, flagd}),
                32'(vecs[i].flags));
            chk($sformatf("vec%0d db", i), fx3_db, vecs[i].db);
        end

        // Overflow: 18 writes into a 16-word buffer.
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            drive(0, 0, 1, 1, 1, 2'b00, Base + 32'(k - 1));
            step("ovf");
            if (k == 13) chk("flagb at 13", 32'(flagb), 32'h1);
            if (k == 14) chk("flagb at 14", 32'(flagb), 32'h0);
            if (k == 15) chk("flaga at 15", 32'(flaga), 32'h1);
            if (k == 16) chk("flaga at 16", 32'(flaga), 32'h0);
        end
        chk("ovf fill", 32'(fill_level), 32'd16);
`ifdef SLFIFO_ERRCNT_EN
        chk("ovf count", 32'(ovf_cnt), 32'd2);
`else
        chk("ovf count", 32'(ovf_cnt), 32'd0);
`endif

        // Full buffer, alternating read and write: fill returns to 16, oldest out.
        for (int p = 0; p < 5; p++) begin
            drive(0, 1, 0, 0, 1, 2'b11, 32'h0);
            step("fullrw rd");
            if (p >= 1) chk($sformatf("fullrw word%0d", p - 1), fx3_db, Base + 32'(p - 1));
            drive(0, 0, 1, 1, 1, 2'b00, Base + 32'h100 + 32'(p));
            step("fullrw wr");
            chk("fullrw fill", 32'(fill_level), 32'd16);
        end
        drive(0, 1, 1, 0, 1, 2'b11, 32'h0);
        step("fullrw tail");
        chk("fullrw word4", fx3_db, Base + 32'd4);

        // pktend pulses with slwr_n high.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 1, 0, 2'b00, 32'h0);
            step("pkt lo");
            drive(0, 1, 1, 1, 1, 2'b00, 32'h0);
            step("pkt hi");
        end
        chk("pkt count", 32'(pkt_cnt), 32'd3);
        chk("pkt fill", 32'(fill_level), 32'd16);

        // Reset in the middle of a read burst.
        drive(0, 1, 0, 0, 1, 2'b11, 32'h0);
        step("midrd");
        step("midrd");
        @(posedge clk);
        model_edge();
        #2;
        rst = 1'b1;
        model_reset();
        update_bus();
        #1;
        chk("async rst fill", 32'(fill_level), 32'h0);
        chk("async rst pkt", 32'(pkt_cnt), 32'h0);
        chk("async rst flags", 32'({flaga, flagb, flagc, flagd}), 32'b1100);
        chk("async rst db", fx3_db, 32'h0);
        step("in rst");
        rst = 1'b0;
        update_bus();
        for (int k = 0; k < 3; k++) begin
            step("post rst");
            chk("pipeline flushed", fx3_db, 32'h0);
        end

        // Randomized traffic: write-heavy, read-heavy, balanced.
        for (int ph = 0; ph < 3; ph++) begin
            int wb, rb;
            wb = (ph == 0) ? 90 : (ph == 1) ? 20 : 50;
            rb = (ph == 0) ? 30 : (ph == 1) ? 90 : 50;
            for (int i = 0; i < 300; i++) begin
                int r;
                logic [1:0] aa;
                r  = int'($urandom_range(0, 9));
                aa = (r < 4) ? 2'b00 : (r < 8) ? 2'b11 : (r == 8) ? 2'b01 : 2'b10;
                drive(logic'($urandom_range(0, 15) == 0),
                      logic'(int'($urandom_range(0, 99)) >= wb),
                      logic'(int'($urandom_range(0, 99)) >= rb),
                      logic'($urandom_range(0, 3) == 0),
                      logic'($urandom_range(0, 7) != 0),
                      aa, $urandom);
                step("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
